seg7_scan_decoder: RTL

- Receive-side counterpart of the team's BCD-to-7-segment driver.
- Samples a time-multiplexed 7-segment bus (segment lines plus active-low digit selects) and rebuilds the per-digit BCD values.
- Filters transition ghosting, flags illegal patterns, and reports when a full scan frame has been captured.
- Used in self-checking display paths and as a loopback monitor on the counter_top display outputs.

---
 rtl/seg7_scan_decoder.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//
// Receive-side monitor for a time-multiplexed 7-segment bus. It samples the
// segment lines and the active-low digit selects, waits until a (select,
// pattern) pair has been stable long enough to rule out transition ghosting,
// and then stores the decoded BCD value for that digit position. Each digit is
// captured at most once per dwell. When every digit has been captured a
// one-cycle frame_done pulse is produced and the per-digit valid flags restart.
//
// Parameters:
//   DIGITS         number of multiplexed digit positions (2..8)
//   STABLE_CYCLES  consecutive identical samples needed to accept a digit (1..15)
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   n_rst       synchronous reset, active-low
//   n_en        capture enable, active-low; high blocks writes, outputs hold
//   seg[6:0]    segment lines, active-high, bit6=a ... bit0=g
//   dig_n       digit selects, active-low, one-hot-low when legal
//   digits      captured codes, digit i in bits [4i+3:4i]
//                 0..9 = decoded digit, F = blank, E = illegal pattern
//   dvalid      per-digit "captured in the current frame" flags
//   err         sticky flag, set when an illegal pattern is captured
//   frame_done  one-cycle pulse, the cycle after dvalid became all-ones
//
// Timing: inputs are registered once; a pattern applied from a given edge is
// first seen by the state machine one cycle later, so the capture state is
// reached 1 + STABLE_CYCLES edges after the inputs first appear, and the
// digit register is written at the end of that capture cycle.
//
// The internal signal 'state' (type state_t) is the state machine's state and
// is the intended probe point for checkers bound to this block.
// -----------------------------------------------------------------------------
module seg7_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  n_en,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     dig_n,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     dvalid,
    output logic                  err,
    output logic                  frame_done
);

    localparam int         IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;

    // Registered copies of the bus; every decision below uses these only.
    logic [6:0]         seg_q;
    logic [DIGITS-1:0]  dig_q;

    // Select decode of the registered sample.
    logic [3:0]         low_cnt;
    logic               samp_valid;
    logic [IDX_W-1:0]   samp_idx;
    logic               samp_same;

    // Dwell tracking: which select/pattern is being timed and for how long.
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   sel_idx_next;
    logic [6:0]         pat_q;
    logic [6:0]         pat_next;
    logic [3:0]         cnt;
    logic [3:0]         cnt_next;
    logic               do_restart;

    // Capture path.
    logic               cap_we;
    logic [3:0]         code;
    logic [4*DIGITS-1:0] digits_next;
    logic [DIGITS-1:0]  dvalid_next;

    // -------------------------------------------------------------------------
    // Segment decode
    // -------------------------------------------------------------------------
    function automatic logic [3:0] seg_decode(input logic [6:0] p);
        logic [3:0] c;
        case (p)
            7'b1111110: c = 4'h0;
            7'b0110000: c = 4'h1;
            7'b1101101: c = 4'h2;
            7'b1111001: c = 4'h3;
            7'b0110011: c = 4'h4;
            7'b1011011: c = 4'h5;
            7'b1011111: c = 4'h6;
            7'b1110000: c = 4'h7;
            7'b1111111: c = 4'h8;
            7'b1111011: c = 4'h9;
            7'b0000000: c = 4'hF;
            default:    c = 4'hE;
        endcase
        return c;
    endfunction

    // -------------------------------------------------------------------------
    // Input sample register. Reset leaves the bus looking idle (no select).
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            seg_q <= 7'd0;
            dig_q <= '1;
        end else begin
            seg_q <= seg;
            dig_q <= dig_n;
        end
    end

    // -------------------------------------------------------------------------
    // Select validity: exactly one low bit. Zero or several low bits are
    // treated the same as "nothing selected".
    // -------------------------------------------------------------------------
    always_comb begin
        low_cnt  = 4'd0;
        samp_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!dig_q[i]) begin
                low_cnt  = low_cnt + 4'd1;
                samp_idx = IDX_W'(i);
            end
        end
        samp_valid = (low_cnt == 4'd1);
    end

    // The current sample continues the dwell being timed.
    assign samp_same = samp_valid && (samp_idx == sel_idx) && (seg_q == pat_q);

    // -------------------------------------------------------------------------
    // Dwell state machine: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            sel_idx <= '0;
            pat_q   <= 7'd0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            sel_idx <= sel_idx_next;
            pat_q   <= pat_next;
        end
    end

    // -------------------------------------------------------------------------
    // Dwell state machine: next state and capture strobe
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        sel_idx_next = sel_idx;
        pat_next     = pat_q;
        cap_we       = 1'b0;
        do_restart   = 1'b0;

        case (state)
            IDLE: begin
                do_restart = 1'b1;
            end

            SETTLE: begin
                if (samp_same) begin
                    // Saturating count; SETTLE is only ever left at CNT_MAX.
                    cnt_next = (cnt < CNT_MAX) ? (cnt + 4'd1) : CNT_MAX;
                    if (cnt_next == CNT_MAX) begin
                        state_next = CAPTURE;
                    end
                end else begin
                    do_restart = 1'b1;
                end
            end

            CAPTURE: begin
                cap_we = !n_en;
                // A sample that already differs from the captured dwell starts
                // the next dwell straight away, so no sample is skipped.
                if (samp_same) begin
                    state_next = HOLD;
                end else begin
                    do_restart = 1'b1;
                end
            end

            HOLD: begin
                // One capture per dwell: stay here until the bus moves on.
                if (!samp_same) begin
                    do_restart = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase

        // Start timing the current sample as a new dwell, or fall back to IDLE
        // when nothing is selected. With STABLE_CYCLES=1 the first sample is
        // already enough, so the dwell goes straight to CAPTURE.
        if (do_restart) begin
            if (samp_valid) begin
                sel_idx_next = samp_idx;
                pat_next     = seg_q;
                cnt_next     = 4'd1;
                state_next   = (CNT_MAX == 4'd1) ? CAPTURE : SETTLE;
            end else begin
                cnt_next     = 4'd0;
                state_next   = IDLE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Capture datapath
    // -------------------------------------------------------------------------
    assign code = seg_decode(pat_q);

    always_comb begin
        digits_next = digits;
        // Completed frame: flags restart before this cycle's capture is
        // applied, so a capture landing on the clear counts for the next frame.
        dvalid_next = (&dvalid) ? '0 : dvalid;
        if (cap_we) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (sel_idx == IDX_W'(i)) begin
                    digits_next[4*i +: 4] = code;
                    dvalid_next[i]        = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            digits     <= {DIGITS{4'hF}};
            dvalid     <= '0;
            err        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            digits     <= digits_next;
            dvalid     <= dvalid_next;
            frame_done <= &dvalid;
            if (cap_we && (code == 4'hE)) begin
                err <= 1'b1;
            end
        end
    end

endmodule
